// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer: single-clock FIFO with occupancy count, threshold flags and sticky error flags.
//   Clock/reset : wclk (rising edge), wrst (asynchronous, active-high)
//   Control     : flush (synchronous pointer/flag clear, memory untouched)
//   Write side  : winc, wdata[DATASIZE]  -> wfull, almost_full, overflow
//   Read side   : rinc -> rdata[DATASIZE] (registered), rvalid, rempty, almost_empty, underflow
//   Status      : count[ADDRSIZE+1] = wptr - rptr
//   Optional    : FIFO_PARITY_EN adds an even-parity bit per word and the parity_err output
module sync_fifo_buffer #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = 2**ADDRSIZE - 2,
  parameter int AEMPTY_THRESH = 2
)(
  input  logic                wclk,
  input  logic                wrst,
  input  logic                flush,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
`ifdef FIFO_PARITY_EN
  output logic                parity_err,
`endif
  output logic                overflow,
  output logic                underflow
);
  localparam int DEPTH = 2**ADDRSIZE;
`ifdef FIFO_PARITY_EN
  localparam int MW = DATASIZE + 1;
`else
  localparam int MW = DATASIZE;
`endif
  localparam logic [ADDRSIZE:0] L_DEPTH  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] L_AFULL  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] L_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THRESH);
  logic [MW-1:0]       r_mem [DEPTH];
  logic [ADDRSIZE:0]   r_wptr, r_rptr, w_count;
  logic [DATASIZE-1:0] r_rdata;
  logic                r_rvalid, r_ovf, r_udf;
  logic                w_full, w_empty, w_wr, w_rd;
  logic [MW-1:0]       w_wword, w_rword;
  // the extra pointer bit makes wptr - rptr an exact occupancy, so full and empty never alias
  assign w_count = r_wptr - r_rptr;
  assign w_full  = w_count == L_DEPTH;
  assign w_empty = w_count == '0;
  // acceptance uses the pre-edge flags; flush suppresses both transfers
  assign w_wr    = winc && !w_full && !flush;
  assign w_rd    = rinc && !w_empty && !flush;
  assign w_rword = r_mem[r_rptr[ADDRSIZE-1:0]];
`ifdef FIFO_PARITY_EN
  assign w_wword = {^wdata, wdata};
`else
  assign w_wword = wdata;
`endif
  always_ff @(posedge wclk)
    if (w_wr) r_mem[r_wptr[ADDRSIZE-1:0]] <= w_wword;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= w_rword[DATASIZE-1:0];
      end
      r_rvalid <= w_rd;
      if (winc && w_full) r_ovf <= 1'b1;
      if (rinc && w_empty) r_udf <= 1'b1;
    end
`ifdef FIFO_PARITY_EN
  logic r_perr;
  // stored word plus its parity bit must reduce to zero; any odd flip shows up here
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) r_perr <= 1'b0;
    else r_perr <= w_rd && ^w_rword;
  assign parity_err = r_perr;
`endif
  assign rdata        = r_rdata;
  assign rvalid       = r_rvalid;
  assign count        = w_count;
  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign almost_full  = w_count >= L_AFULL;
  assign almost_empty = w_count <= L_AEMPTY;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule
